// File: rtl/spi_flash_responder.sv
// SPI flash read responder: 0x03 read, 0x9F JEDEC ID, optional 0x0B fast read.
// Define SPI_FLASH_FAST_READ_EN to enable 0x0B and the dummy-cycle phase.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS    = 24,
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4016,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         RSTB,
    input  logic                         csb,
    input  logic                         sclk,
    input  logic                         io0,
    output logic                         io1,
    output logic                         io1_oe,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [7:0]                   ld_data,
    output logic [7:0]                   err_cnt,
    output logic                         busy
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    // Input shift width: wide enough for a command byte and an effective address.
    localparam int unsigned SW = (AW > 8) ? AW : 8;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StData, StId, StIgnore
    } state_e;

    state_e          state_q;
    logic [1:0]      csb_sync_q, sclk_sync_q, io0_sync_q;
    logic            csb_prev_q, sclk_prev_q;
    logic [1:0]      settle_q;
    logic            armed_q, rdy_en_q, fast_q;
    logic [SW-2:0]   in_sr_q;
    logic [7:0]      cnt_q, out_sr_q, err_cnt_q;
    logic [AW-1:0]   addr_q;
    logic [1:0]      id_idx_q;
    logic            io1_q, io1_oe_q;
    logic [7:0]      mem [MEM_DEPTH];

    logic            csb_s, sclk_s, io0_s, sclk_rise, sclk_fall, csb_fall;
    logic [SW-1:0]   shift_in;
    logic [AW-1:0]   eff_addr, addr_inc;
    logic [1:0]      id_next;
    logic [7:0]      id_byte;

    assign csb_s     = csb_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign io0_s     = io0_sync_q[1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csb_fall  = ~csb_s & csb_prev_q;
    assign shift_in  = {in_sr_q, io0_s};
    assign eff_addr  = shift_in[AW-1:0];
    assign addr_inc  = addr_q + 1'b1;

    always_comb begin
        id_next = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
        unique case (id_next)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            state_q     <= StIdle;
            csb_sync_q  <= 2'b11;
            sclk_sync_q <= 2'b00;
            io0_sync_q  <= 2'b00;
            csb_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            rdy_en_q    <= 1'b0;
            fast_q      <= 1'b0;
            in_sr_q     <= '0;
            cnt_q       <= 8'd0;
            out_sr_q    <= 8'd0;
            err_cnt_q   <= 8'd0;
            addr_q      <= '0;
            id_idx_q    <= 2'd0;
            io1_q       <= 1'b0;
            io1_oe_q    <= 1'b0;
        end else begin
            csb_sync_q  <= {csb_sync_q[0], csb};
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            io0_sync_q  <= {io0_sync_q[0], io0};
            csb_prev_q  <= csb_s;
            sclk_prev_q <= sclk_s;
            rdy_en_q    <= 1'b1;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            // A transaction cut by reset is ignored until csb is genuinely seen high.
            if (settle_q == 2'd3 && csb_s) armed_q <= 1'b1;

            if (csb_s) begin
                state_q  <= StIdle;
                cnt_q    <= 8'd0;
                io1_q    <= 1'b0;
                io1_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q <= 8'd0;
                        if (csb_fall && armed_q) state_q <= StCmd;
                    end
                    StCmd: if (sclk_rise) begin
                        in_sr_q <= shift_in[SW-2:0];
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == 8'd7) begin
                            cnt_q <= 8'd0;
                            case (shift_in[7:0])
                                8'h03: begin
                                    state_q <= StAddr;
                                    fast_q  <= 1'b0;
                                end
`ifdef SPI_FLASH_FAST_READ_EN
                                8'h0B: begin
                                    state_q <= StAddr;
                                    fast_q  <= 1'b1;
                                end
`endif
                                8'h9F: begin
                                    state_q  <= StId;
                                    io1_oe_q <= 1'b1;
                                    out_sr_q <= JEDEC_ID[23:16];
                                    id_idx_q <= 2'd0;
                                end
                                default: begin
                                    state_q <= StIgnore;
                                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                                end
                            endcase
                        end
                    end
                    StAddr: if (sclk_rise) begin
                        in_sr_q <= shift_in[SW-2:0];
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q  <= 8'd0;
                            addr_q <= eff_addr;
                            if (fast_q && DUMMY_CYCLES != 0) begin
                                state_q <= StDummy;
                            end else begin
                                state_q  <= StData;
                                io1_oe_q <= 1'b1;
                                out_sr_q <= mem[eff_addr];
                            end
                        end
                    end
                    StDummy: if (sclk_rise) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_q    <= 8'd0;
                            state_q  <= StData;
                            io1_oe_q <= 1'b1;
                            out_sr_q <= mem[addr_q];
                        end
                    end
                    StData: begin
                        if (sclk_fall) begin
                            io1_q    <= out_sr_q[7];
                            out_sr_q <= {out_sr_q[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd7) begin
                                cnt_q    <= 8'd0;
                                addr_q   <= addr_inc;
                                out_sr_q <= mem[addr_inc];
                            end
                        end
                    end
                    StId: begin
                        if (sclk_fall) begin
                            io1_q    <= out_sr_q[7];
                            out_sr_q <= {out_sr_q[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd7) begin
                                cnt_q    <= 8'd0;
                                id_idx_q <= id_next;
                                out_sr_q <= id_byte;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io1      = io1_q;
    assign io1_oe   = io1_oe_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = ~csb_s;
    assign ld_ready = rdy_en_q & (state_q == StIdle) & csb_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: vector table plus reset/abort sequences.
module tb_spi_flash_responder;
    localparam int HALF = 40;
    localparam logic [23:0] JID = 24'hEF4016;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk, RSTB, csb, sclk, io0, io1, io1_oe;
    logic        ld_valid, ld_ready, busy;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data, err_cnt;

    spi_flash_responder dut (
        .clk      (clk),
        .RSTB     (RSTB),
        .csb      (csb),
        .sclk     (sclk),
        .io0      (io0),
        .io1      (io1),
        .io1_oe   (io1_oe),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [4096];
    logic [7:0]  err_m = 8'd0;
    logic [7:0]  exp_q [$];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        io0 = b;
        #(HALF);
        r  = io1;
        oe = io1_oe;
        sclk = 1'b1;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oev);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r, o);
            rx[i]  = r;
            oev[i] = o;
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        int t;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        t = 0;
        while (!ld_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ld_ready) check("ld_ready_timeout", {31'd0, ld_ready}, 32'd1);
        else @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int n);
        logic [7:0]  rx, oev, exp_b;
        logic [11:0] a;
        logic        exp_oe, rd;
        rd = (cmd == 8'h03) || (cmd == 8'h0B && FAST);
        exp_oe = rd || (cmd == 8'h9F);
        for (int i = 0; i < n; i++) begin
            a = addr[11:0] + 12'(i);
            if (rd) exp_q.push_back(mem_m[a]);
            else if (cmd == 8'h9F) begin
                case (i % 3)
                    0:       exp_q.push_back(JID[23:16]);
                    1:       exp_q.push_back(JID[15:8]);
                    default: exp_q.push_back(JID[7:0]);
                endcase
            end else exp_q.push_back(8'h00);
        end
        if (!exp_oe && err_m != 8'hFF) err_m = err_m + 8'd1;

        @(negedge clk);
        csb = 1'b0;
        #(2 * HALF);
        check("busy", {31'd0, busy}, 32'd1);
        check("ld_ready_busy", {31'd0, ld_ready}, 32'd0);
        spi_byte(cmd, rx, oev);
        if (cmd == 8'h03 || cmd == 8'h0B) begin
            spi_byte(addr[23:16], rx, oev);
            spi_byte(addr[15:8], rx, oev);
            spi_byte(addr[7:0], rx, oev);
            if (cmd == 8'h0B) spi_byte(8'h00, rx, oev);
        end
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx, oev);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_b = exp_q.pop_front();
                check($sformatf("data cmd=%0h byte%0d", cmd, i), {24'd0, rx}, {24'd0, exp_b});
                check($sformatf("oe cmd=%0h byte%0d", cmd, i), {24'd0, oev},
                      exp_oe ? 32'hFF : 32'h00);
            end
        end
        #(HALF);
        csb = 1'b1;
        #200;
        check($sformatf("err_cnt after cmd=%0h", cmd), {24'd0, err_cnt}, {24'd0, err_m});
        check("io1_oe_idle", {31'd0, io1_oe}, 32'd0);
    endtask

    task automatic cmd_only(input logic [7:0] cmd);
        logic [7:0] rx, oev;
        @(negedge clk);
        csb = 1'b0;
        #(2 * HALF);
        spi_byte(cmd, rx, oev);
        #(HALF);
        csb = 1'b1;
        #100;
        if (err_m != 8'hFF) err_m = err_m + 8'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx, oev;
        logic       r, o, oe_or;
        csb = 1'b1; sclk = 1'b0; io0 = 1'b0; ld_valid = 1'b0;
        ld_addr = '0; ld_data = '0; RSTB = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_io1", {31'd0, io1}, 32'd0);
        check("rst_io1_oe", {31'd0, io1_oe}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        RSTB = 1'b1;
        @(negedge clk);
        check("ld_ready_after_release", {31'd0, ld_ready}, 32'd1);

        for (int i = 0; i < 16; i++) load(12'(i), 8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) load(12'hFF0 + 12'(i), 8'h50 + 8'(i));

        vecs[0] = '{8'h03, 24'h000004, 4};
        vecs[1] = '{8'h03, 24'h000FFE, 4};
        vecs[2] = '{8'h9F, 24'h000000, 6};
        vecs[3] = '{8'h0B, 24'h000000, 2};
        vecs[4] = '{8'h03, 24'h123008, 2};
        vecs[5] = '{8'h55, 24'h000000, 1};
        for (int v = 0; v < 6; v++) run_txn(vecs[v].cmd, vecs[v].addr, vecs[v].n);

        // Saturating error counter.
        for (int i = 0; i < 300; i++) cmd_only(8'h55);
        check("err_cnt_saturated", {24'd0, err_cnt}, {24'd0, err_m});

        // csb raised after 4 address bits; the following read must be clean.
        @(negedge clk);
        csb = 1'b0;
        #(2 * HALF);
        spi_byte(8'h03, rx, oev);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r, o);
        #(HALF);
        csb = 1'b1;
        #200;
        run_txn(8'h03, 24'h00000C, 2);

        // Reset pulse during DATA.
        @(negedge clk);
        csb = 1'b0;
        #(2 * HALF);
        spi_byte(8'h03, rx, oev);
        spi_byte(8'h00, rx, oev);
        spi_byte(8'h00, rx, oev);
        spi_byte(8'h08, rx, oev);
        spi_byte(8'h00, rx, oev);
        check("pre_reset_data", {24'd0, rx}, {24'd0, mem_m[8]});
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
        RSTB = 1'b0;
        #1;
        check("reset_io1_oe_immediate", {31'd0, io1_oe}, 32'd0);
        check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        err_m = 8'd0;
        #19;
        RSTB = 1'b1;
        oe_or = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spi_bit(1'b0, r, o);
            oe_or = oe_or | o;
        end
        check("oe_after_reset_midtxn", {31'd0, oe_or}, 32'd0);
        #(HALF);
        csb = 1'b1;
        #200;
        run_txn(8'h03, 24'h000008, 2);
        run_txn(8'h03, 24'h000FFE, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
